// File: rtl/fifo_uart_sched_pkg.sv
// Shared types and constants for the FIFO-to-UART scheduler.
// HEX_ASCII_EN adds the low-nibble state and the nibble-to-ASCII helper.
package fifo_uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_ACK  = 3'd4,
    S_BUSY = 3'd5,
    S_GAP  = 3'd6
`ifdef HEX_ASCII_EN
    ,
    S_LO   = 3'd7
`endif
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

`ifdef HEX_ASCII_EN
  // Uppercase hex digit: '0'-'9' then 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    if (nib < 4'd10) begin
      return 8'h30 + wide;
    end
    return 8'h37 + wide;
  endfunction
`endif

endpackage

// File: rtl/fifo_uart_sched_gap_timer.sv
// Loadable 32-bit down-counter; done is high while the count sits at zero.
// Shared between the start-acknowledge timeout and the inter-byte/frame gap.
module gap_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 32'd0);

endmodule

// File: rtl/fifo_uart_sched.sv
// Drains the AD sample FIFO into the UART TX core, one byte at a time, with gaps and a start timeout.
// Macro HEX_ASCII_EN: data bytes other than CR/LF are sent as two uppercase ASCII hex characters.
module fifo_uart_sched
  import fifo_uart_pkg::*;
#(
  parameter int unsigned BYTE_GAP    = 16,
  parameter int unsigned FRAME_GAP   = 100_000,
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr_err,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_q,
  output logic               fifo_rdreq,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               active,
  output logic               frame_done,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               timeout_err,
  output logic [STATE_W-1:0] dbg_state
);

  // UART handshake: tx_start is a one-cycle request with tx_data stable; tx_busy
  // rising acknowledges it, and tx_busy falling marks the character finished.

  state_e           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmr_load;
  logic [31:0]      tmr_val;
  logic             tmr_done;
`ifdef HEX_ASCII_EN
  logic             lo_pend_q, lo_pend_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
`endif

  gap_timer u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    frame_done_d  = 1'b0;
    byte_cnt_d    = byte_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;
    tmr_load      = 1'b0;
    tmr_val       = 32'd0;
`ifdef HEX_ASCII_EN
    lo_pend_d     = lo_pend_q;
    lo_nib_d      = lo_nib_q;
`endif
    // A timeout later in this block overrides the clear.
    if (clr_err) begin
      timeout_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty && !tx_busy) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef HEX_ASCII_EN
        if (fifo_q == CR || fifo_q == LF) begin
          tx_data_d = fifo_q;
          lo_pend_d = 1'b0;
        end else begin
          tx_data_d = nibble_to_ascii(fifo_q[7:4]);
          lo_nib_d  = fifo_q[3:0];
          lo_pend_d = 1'b1;
        end
`else
        tx_data_d = fifo_q;
`endif
        tx_start_d = 1'b1;
        tmr_load   = 1'b1;
        tmr_val    = ACK_TIMEOUT - 32'd1;
        state_d    = S_ACK;
      end
      S_ACK: begin
        if (tx_busy) begin
          state_d = S_BUSY;
        end else if (tmr_done) begin
          timeout_err_d = 1'b1;
          tmr_load      = 1'b1;
          tmr_val       = BYTE_GAP;
          state_d       = S_GAP;
`ifdef HEX_ASCII_EN
          lo_pend_d     = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        if (!tx_busy) begin
          tmr_load = 1'b1;
          state_d  = S_GAP;
          if (tx_data_q == LF) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            tmr_val      = FRAME_GAP;
          end else begin
            tmr_val = BYTE_GAP;
          end
        end
      end
      S_GAP: begin
        if (tmr_done) begin
`ifdef HEX_ASCII_EN
          state_d = lo_pend_q ? S_LO : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef HEX_ASCII_EN
      S_LO: begin
        tx_data_d  = nibble_to_ascii(lo_nib_q);
        lo_pend_d  = 1'b0;
        tx_start_d = 1'b1;
        tmr_load   = 1'b1;
        tmr_val    = ACK_TIMEOUT - 32'd1;
        state_d    = S_ACK;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      byte_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`ifdef HEX_ASCII_EN
      lo_pend_q     <= 1'b0;
      lo_nib_q      <= 4'h0;
`endif
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      frame_done_q  <= frame_done_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
`ifdef HEX_ASCII_EN
      lo_pend_q     <= lo_pend_d;
      lo_nib_q      <= lo_nib_d;
`endif
    end
  end

  assign fifo_rdreq  = (state_q == S_RD);
  assign active      = (state_q != S_IDLE);
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign frame_done  = frame_done_q;
  assign byte_cnt    = byte_cnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

endmodule
